// File: rtl/bus_wait_slave.sv
// Word-addressed SRAM bus target with a fixed number of wait states.
// Completion is signalled with a one-cycle active-low rdy_ pulse. rd_data is zero outside that pulse.
module bus_wait_slave #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rdy_,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is valid when cs_ and as_ are both low at a rising edge in IDLE.
    // The master holds the request until it sees rdy_ low. READY ignores cs_/as_.
    // Releasing cs_ or as_ while in WAIT abandons the transfer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t state, next_state;

    logic [31:0]       mem [2**ADDR_W];
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              enter_ready;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_rw;
    logic [31:0]       acc_wdata;

    assign accept    = (state == S_IDLE) && !cs_ && !as_;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
            end
            S_WAIT: begin
                if (cs_ || as_)     next_state = S_IDLE;
                else if (cnt == 4'd1) next_state = S_READY;
            end
            S_READY: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With zero wait states READY is entered on the accepting edge, before the latches load.
    always_comb begin
        enter_ready = (next_state == S_READY) && (state != S_READY);
        acc_addr    = (state == S_IDLE) ? addr    : addr_q;
        acc_rw      = (state == S_IDLE) ? rw      : rw_q;
        acc_wdata   = (state == S_IDLE) ? wr_data : wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            cnt     <= 4'(WAIT_CYCLES);
            addr_q  <= addr;
            rw_q    <= rw;
            wdata_q <= wr_data;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_    <= 1'b1;
            busy    <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            rdy_    <= !enter_ready;
            busy    <= (next_state != S_IDLE);
            rd_data <= (enter_ready && acc_rw) ? mem[acc_addr] : 32'd0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_ready && !acc_rw) mem[acc_addr] <= acc_wdata;
    end

endmodule
